// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared constants and helpers for the operand scoreboard
// Provides register-file geometry, the r0 index and the counter-width helper.
package scoreboard_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Width needed to hold a countdown that starts at lat.
    function automatic int cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/sb_countdown.sv
// rtl/sb_countdown.sv - one loadable down-counter with a nonzero flag
// Ports:
//   clock_i     rising-edge clock
//   reset_i     asynchronous active-low reset
//   load_i      reload the counter with load_val_i this cycle
//   load_val_i  reload value
//   nonzero_o   counter is not zero (register still pending)
module sb_countdown #(
    parameter int W = 2
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         nonzero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A reload takes priority over the decrement in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/operand_scoreboard.sv
// rtl/operand_scoreboard.sv - decode-stage operand scoreboard for loads and mult/div
// Optional feature: define SCOREBOARD_MD_BYPASS_EN to let the md_done cycle
// already treat the mult/div destination as free for hazard checks.
// Ports:
//   clock_i, reset_i          clock, asynchronous active-low reset
//   id_valid_i                decode holds a valid instruction
//   id_rs_i, id_rt_i          source register indices
//   id_rd_i, id_wen_i         destination index and its write enable
//   id_is_load_i, id_is_md_i  instruction class
//   md_done_i                 mult/div unit completes this cycle
//   flush_i                   kill the instruction in decode
//   stall_o, issue_o          hold fetch/decode, qualified handoff to execute
//   busy_mask_o               per-register pending bits (bit 0 always 0)
//   md_busy_o                 a mult/div is outstanding
module operand_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int LOAD_LAT = 2
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                id_valid_i,
    input  logic [REG_W-1:0]    id_rs_i,
    input  logic [REG_W-1:0]    id_rt_i,
    input  logic [REG_W-1:0]    id_rd_i,
    input  logic                id_wen_i,
    input  logic                id_is_load_i,
    input  logic                id_is_md_i,
    input  logic                md_done_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                issue_o,
    output logic [NUM_REGS-1:0] busy_mask_o,
    output logic                md_busy_o
);

    localparam int CW = cnt_w(LOAD_LAT);

    logic [NUM_REGS-1:0] cnt_nz;
    logic [NUM_REGS-1:0] load_hit;
    logic [NUM_REGS-1:0] hazard_mask;
    logic                md_busy_q, md_busy_d;
    logic [REG_W-1:0]    md_dst_q, md_dst_d;
    logic                md_clear_now;
    logic                md_eff;
    logic                raw, waw, structural;
    logic                ld_issue, md_set;

    // Load countdowns; r0 is never loaded so its counter stays at zero.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign load_hit[r] = 1'b0;
        end else begin : g_reg
            assign load_hit[r] = ld_issue && (id_rd_i == REG_W'(r));
        end
        sb_countdown #(
            .W (CW)
        ) u_cnt (
            .clock_i    (clock_i),
            .reset_i    (reset_i),
            .load_i     (load_hit[r]),
            .load_val_i (CW'(LOAD_LAT)),
            .nonzero_o  (cnt_nz[r])
        );
    end

`ifdef SCOREBOARD_MD_BYPASS_EN
    assign md_clear_now = md_done_i;
`else
    assign md_clear_now = 1'b0;
`endif

    // md_eff is the mult/div busy state as seen by hazard checks; with the
    // bypass it already drops in the completion cycle.
    assign md_eff = md_busy_q & ~md_clear_now;

    always_comb begin
        busy_mask_o = cnt_nz;
        if (md_busy_q) begin
            busy_mask_o[md_dst_q] = 1'b1;
        end
        busy_mask_o[0] = 1'b0;
    end

    always_comb begin
        hazard_mask = cnt_nz;
        if (md_eff) begin
            hazard_mask[md_dst_q] = 1'b1;
        end
        hazard_mask[0] = 1'b0;
    end

    assign raw        = hazard_mask[id_rs_i] | hazard_mask[id_rt_i];
    assign waw        = id_wen_i & md_eff & (id_rd_i == md_dst_q);
    assign structural = id_is_md_i & md_eff;

    assign stall_o = id_valid_i & ~flush_i & (raw | waw | structural);
    assign issue_o = id_valid_i & ~stall_o & ~flush_i;

    assign ld_issue = issue_o & id_wen_i & id_is_load_i & (id_rd_i != REG_ZERO);
    assign md_set   = issue_o & id_wen_i & id_is_md_i & (id_rd_i != REG_ZERO);

    // A new mult/div issuing in the completion cycle wins over the clear.
    always_comb begin
        md_busy_d = md_busy_q;
        md_dst_d  = md_dst_q;
        if (md_set) begin
            md_busy_d = 1'b1;
            md_dst_d  = id_rd_i;
        end else if (md_done_i) begin
            md_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            md_busy_q <= 1'b0;
            md_dst_q  <= REG_ZERO;
        end else begin
            md_busy_q <= md_busy_d;
            md_dst_q  <= md_dst_d;
        end
    end

    assign md_busy_o = md_busy_q;

endmodule

// File: tb/tb_operand_scoreboard.sv
// tb/tb_operand_scoreboard.sv - self-checking bench for operand_scoreboard
module tb_operand_scoreboard;

    localparam int LAT = 2;
`ifdef SCOREBOARD_MD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid, id_wen, id_is_load, id_is_md, md_done, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        stall, issue, md_busy;
    logic [31:0] busy_mask;

    always #5 clock = ~clock;

    operand_scoreboard #(.LOAD_LAT(LAT)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_rd_i      (id_rd),
        .id_wen_i     (id_wen),
        .id_is_load_i (id_is_load),
        .id_is_md_i   (id_is_md),
        .md_done_i    (md_done),
        .flush_i      (flush),
        .stall_o      (stall),
        .issue_o      (issue),
        .busy_mask_o  (busy_mask),
        .md_busy_o    (md_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each register's load result is available from an
    // absolute cycle number on; one pending mult/div with its destination.
    int cyc = 0;
    int ld_ready[32];
    bit md_pend;
    int md_dst_m;

    logic obs_stall, obs_issue;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit pending(input int r, input bit md_view);
        if (r == 0) return 1'b0;
        return (cyc < ld_ready[r]) || (md_view && md_dst_m == r);
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        for (int r = 0; r < 32; r++) m[r] = pending(r, md_pend);
        return m;
    endfunction

    function automatic bit exp_hazard();
        bit md_eff = md_pend && !(BYP && md_done);
        bit raw    = pending(int'(id_rs), md_eff) || pending(int'(id_rt), md_eff);
        bit waw    = id_wen && md_eff && (int'(id_rd) == md_dst_m);
        bit strc   = id_is_md && md_eff;
        return raw || waw || strc;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) ld_ready[r] = 0;
        md_pend  = 1'b0;
        md_dst_m = 0;
    endtask

    task automatic set_inst(input bit v, input int rs, input int rt, input int rd,
                            input bit wen, input bit ld, input bit md);
        id_valid   = v;
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_rd      = 5'(rd);
        id_wen     = wen;
        id_is_load = ld;
        id_is_md   = md;
    endtask

    // One clock: compare outputs at the falling edge, then advance the model.
    task automatic step();
        bit es, ei;
        @(negedge clock);
        es = id_valid && !flush && exp_hazard();
        ei = id_valid && !es && !flush;
        obs_stall = stall;
        obs_issue = issue;
        check("stall", 32'(stall), 32'(es));
        check("issue", 32'(issue), 32'(ei));
        check("busy_mask", busy_mask, exp_mask());
        check("md_busy", 32'(md_busy), 32'(md_pend));
        @(posedge clock);
        if (ei && id_wen && id_rd != 5'd0 && id_is_load) ld_ready[id_rd] = cyc + LAT + 1;
        if (ei && id_wen && id_rd != 5'd0 && id_is_md) begin
            md_pend  = 1'b1;
            md_dst_m = int'(id_rd);
        end else if (md_done) begin
            md_pend = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        set_inst(0, 0, 0, 0, 0, 0, 0);
        md_done = 1'b0;
        flush   = 1'b0;
        reset   = 1'b0;
        #1;
        model_clear();
        check("rst_busy_mask", busy_mask, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_issue", 32'(issue), 32'h0);
        check("rst_md_busy", 32'(md_busy), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Cycles until the current decode instruction issues (bounded).
    task automatic cycles_to_issue(input string tag, output int n);
        n = 0;
        step();
        while (!obs_issue && n < 20) begin
            n++;
            step();
        end
        if (!obs_issue) check({tag, "_timeout"}, 32'(obs_issue), 32'h1);
    endtask

    initial begin
        int n;
        model_clear();
        reset = 1'b1;
        do_reset();

        // Load-use stall.
        set_inst(1, 1, 2, 5, 1, 1, 0);
        step();
        set_inst(1, 5, 0, 10, 1, 0, 0);
        cycles_to_issue("load_use", n);
        check("load_use_stalls", 32'(n), 32'(LAT));
        check("load_use_mask5", 32'(busy_mask[5]), 32'h0);

        // Mult/div RAW through rt.
        set_inst(1, 1, 2, 8, 1, 0, 1);
        step();
        set_inst(1, 0, 8, 11, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_stall) n++;
        end
        check("md_raw_stalls", 32'(n), 32'd10);
        md_done = 1'b1;
        step();
        md_done = 1'b0;
        n = 0;
        while (!obs_issue && n < 20) begin
            n++;
            step();
        end
        check("md_release_delay", 32'(n), BYP ? 32'd0 : 32'd1);
        set_inst(0, 0, 0, 0, 0, 0, 0);
        step();

        // Structural then WAW against an outstanding mult/div to r8.
        set_inst(1, 1, 2, 8, 1, 0, 1);
        step();
        set_inst(1, 1, 2, 9, 1, 0, 1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_stall) n++;
        end
        check("struct_stalls", 32'(n), 32'd4);
        set_inst(1, 1, 2, 8, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (obs_stall) n++;
        end
        check("waw_stalls", 32'(n), 32'd4);
        md_done = 1'b1;
        step();
        md_done = 1'b0;
        set_inst(0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        // r0 immunity.
        set_inst(1, 1, 2, 0, 1, 1, 0);
        step();
        set_inst(1, 0, 0, 4, 1, 0, 0);
        step();
        check("r0_mask", busy_mask, 32'h0);
        check("r0_no_stall", 32'(obs_stall), 32'h0);

        // Flush during a stalled reader; counter keeps running.
        set_inst(1, 1, 2, 5, 1, 1, 0);
        step();
        set_inst(1, 5, 5, 6, 1, 0, 0);
        flush = 1'b1;
        step();
        check("flush_stall", 32'(obs_stall), 32'h0);
        check("flush_issue", 32'(obs_issue), 32'h0);
        flush = 1'b0;
        step();
        step();
        check("flush_mask5_drained", 32'(busy_mask[5]), 32'h0);

        // Reset with r5 pending.
        set_inst(1, 1, 2, 5, 1, 1, 0);
        step();
        check("pre_reset_mask5", 32'(busy_mask[5]), 32'h1);
        do_reset();

        // Back-to-back reloads of r3.
        set_inst(1, 1, 2, 3, 1, 1, 0);
        step();
        step();
        set_inst(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LAT; i++) step();
        check("reload_mask3_clear", 32'(busy_mask[3]), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int kind = $urandom_range(0, 3);
            set_inst($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), kind != 3, kind == 1, kind == 2);
            md_done = ($urandom_range(0, 9) < 2);
            flush   = ($urandom_range(0, 9) == 0);
            step();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_scoreboard.md
# operand_scoreboard

Decode-stage operand scoreboard that sits directly downstream of the instruction decoder and consumes its `rs`/`rt` source-register indices plus the destination index. It records in-flight register writes: loads with a fixed latency, and a single variable-latency multiply/divide. It raises `stall` whenever a decoded instruction would read, or overwrite, a register whose result is not yet available. The IF/ID latch and PC hold on `stall`; `issue` is the qualified handoff into the execute stage.

## Interface
- `LOAD_LAT`, 2, cycles a load destination stays busy after issue (1..7)
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  decode holds a valid instruction
- `id_rs`  in  5  source A index from decoder
- `id_rt`  in  5  source B index from decoder
- `id_rd`  in  5  destination index
- `id_wen`  in  1  instruction writes `id_rd`
- `id_is_load`  in  1  instruction is a load
- `id_is_md`  in  1  instruction is a mult/div
- `md_done`  in  1  mult/div unit completes its result this cycle
- `flush`  in  1  kill the instruction in decode this cycle
- `stall`  out  1  hold fetch/decode
- `issue`  out  1  `id_valid & ~stall & ~flush`
- `busy_mask`  out  32  bit r set when register r is pending
- `md_busy`  out  1  a mult/div is outstanding

## Operation
- State:
  - 32 load countdown counters, width `$clog2(LOAD_LAT+1)`
  - `md_busy` flag
  - 5-bit `md_dst`
- `busy_mask[r]` = (counter[r] != 0) | (`md_busy` & `md_dst`==r). Bit 0 is forced 0 at all times; writes to r0 are never tracked.
- Hazard terms, evaluated only when `id_valid`:
  - RAW: `busy_mask[id_rs]` or `busy_mask[id_rt]`. Both sources are always checked.
  - WAW: `id_wen` and `md_busy` and `id_rd`==`md_dst`.
  - Structural: `id_is_md` and `md_busy`.
- `stall` = `id_valid` & ~`flush` & (RAW | WAW | structural).
- On `issue`:
  - `id_wen & id_is_load & id_rd!=0`: counter[id_rd] <= `LOAD_LAT`. This reloads the counter even if it is nonzero.
  - `id_is_md & id_wen & id_rd!=0`: `md_busy` <= 1, `md_dst` <= `id_rd`.
  - ALU writes are not tracked; forwarding covers them.
- Every cycle, each nonzero counter decrements by 1, unless it is being reloaded that cycle.
- `md_done`: `md_busy` <= 0 at the next edge. If `md_done` arrives while `md_busy`=0, it is ignored.
- Simultaneous `md_done` and an issuing mult/div: the set wins, and `md_dst` takes the new value.
- `flush` suppresses issue only. Loads and mult/divs already issued still complete and stay tracked.

## Timing
- `stall`, `issue` and `busy_mask` are combinational from the inputs and the registered state. State updates on the rising edge of `clock`.
- Reset (async assert, sync deassert expected upstream):
  - all counters 0, `md_busy`=0, `md_dst`=0
  - `busy_mask`=0, `stall`=0, `issue`=0
- Reset asserted mid-operation drops all pending entries immediately.
- Load-use: a consumer in the cycle after the load issues sees `stall` for `LOAD_LAT` cycles, then issues.

## Configuration
- `SCOREBOARD_MD_BYPASS_EN` defined:
  - In the `md_done` cycle, `md_dst` is treated as not busy for RAW, WAW and structural checks.
  - A dependent instruction issues in the same cycle as `md_done`.
- Undefined: the clear takes effect only at the next edge, so a dependent instruction stalls one extra cycle.

## Structure
- `scoreboard_pkg`:
  - `REG_W`=5, `NUM_REGS`=32
  - `cnt_w(lat)` function
  - `REG_ZERO`=5'd0
- Sub-module `sb_countdown`: one loadable down-counter with a `nonzero` output. It is generated 32 times, and the r0 instance is tied off.

## Test plan
- Load-use stall:
  - Stimulus: LOAD_LAT=2. Issue load to r5. Next cycle, decode reads rs=5.
  - Required: `stall`=1 for 2 cycles, then `issue`=1; `busy_mask[5]` clears on the same edge.
- Mult/div RAW:
  - Stimulus: issue mult/div to r8, hold `md_done`=0 for 10 cycles with a reader of rt=8 in decode, then pulse `md_done`.
  - Required: stall throughout. With the macro, `issue` in the `md_done` cycle; without it, `issue` one cycle later.
- Structural and WAW:
  - Stimulus: with mult/div to r8 outstanding, present a second mult/div (rd=9), then an ALU op with rd=8.
  - Required: both stall until `md_done`.
- r0 immunity:
  - Stimulus: issue load to r0, then read rs=0.
  - Required: `busy_mask`=0, no stall.
- Flush and reset:
  - Stimulus: `flush` during a stalled reader.
  - Required: `stall`=0, `issue`=0, and the load counter keeps counting.
  - Stimulus: assert `reset` with r5 pending.
  - Required: `busy_mask`=0 immediately.
- Reload:
  - Stimulus: two back-to-back loads to r3.
  - Required: `busy_mask[3]` stays set `LOAD_LAT` cycles after the second load.
